intr_arb: RTL and testbench

//   PDP-11 bus-request arbiter. Sits downstream of the iopage device register blocks
//   (line clock, console, disk). Collects their interrupt/vector outputs, picks the highest

---
 rtl/intr_arb.sv | 144 ++++++++++++++
 tb/tb_intr_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/intr_arb.sv
// intr_arb: PDP-11 bus-request arbiter.
// Picks the highest eligible BR level among the device requests, presents a
// single request plus vector to the CPU and returns the CPU acknowledge to the
// winning device as a one-cycle one-hot pulse.
module intr_arb #(
  parameter int                   NUM_SRC   = 8,
  parameter logic [3*NUM_SRC-1:0] SRC_LEVEL = 24'o44445446
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     irq_in,
  input  logic [8*NUM_SRC-1:0]   vec_in,
  input  logic [2:0]             cpu_ipl,
  input  logic                   interrupt_ack,
  output logic                   interrupt,
  output logic [7:0]             vector,
  output logic [2:0]             int_level,
  output logic [NUM_SRC-1:0]     ack_out
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_win_idx;
  logic [7:0]       r_vector;
  logic [2:0]       r_level;

  state_t           w_state_next;
  logic [IDX_W-1:0] w_win_idx_next;
  logic [7:0]       w_vector_next;
  logic [2:0]       w_level_next;

  logic [NUM_SRC-1:0] w_elig;
  logic [2:0]         w_lvl [NUM_SRC];

  logic               w_any;
  logic [IDX_W-1:0]   w_best_idx;
  logic [2:0]         w_best_lvl;
  logic [7:0]         w_best_vec;

  // Per-source level and eligibility. Level 0 can never beat any IPL, but it
  // is excluded explicitly so the intent is obvious.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_lvl[gi]  = SRC_LEVEL[3*gi +: 3];
    assign w_elig[gi] = irq_in[gi] && (w_lvl[gi] != 3'd0) && (w_lvl[gi] > cpu_ipl);
  end

  // Combinational arbitration: highest level wins; scanning upward and only
  // replacing on a strictly higher level keeps ties on the lowest index.
  always_comb begin
    w_any      = 1'b0;
    w_best_idx = '0;
    w_best_lvl = 3'd0;
    w_best_vec = 8'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_elig[i] && (!w_any || (w_lvl[i] > w_best_lvl))) begin
        w_any      = 1'b1;
        w_best_idx = IDX_W'(i);
        w_best_lvl = w_lvl[i];
        w_best_vec = vec_in[8*i +: 8];
      end
    end
  end

  // Next-state and output decode. The winner registers only move when a new
  // arbitration result is accepted (IDLE, or REQ without an acknowledge).
  always_comb begin
    w_state_next   = r_state;
    w_win_idx_next = r_win_idx;
    w_vector_next  = r_vector;
    w_level_next   = r_level;
    interrupt      = 1'b0;
    ack_out        = '0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next   = S_REQ;
          w_win_idx_next = w_best_idx;
          w_vector_next  = w_best_vec;
          w_level_next   = w_best_lvl;
        end
      end

      S_REQ: begin
        interrupt = 1'b1;
        if (interrupt_ack) begin
          // Acknowledge beats any simultaneous winner change.
          w_state_next = S_ACK;
        end else if (w_any) begin
          w_win_idx_next = w_best_idx;
          w_vector_next  = w_best_vec;
          w_level_next   = w_best_lvl;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      S_ACK: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (r_win_idx == IDX_W'(i)) begin
            ack_out[i] = 1'b1;
          end
        end
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        // Holdoff cycle giving the device time to drop its request.
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and latched-winner registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_win_idx <= '0;
      r_vector  <= 8'd0;
      r_level   <= 3'd0;
    end else begin
      r_state   <= w_state_next;
      r_win_idx <= w_win_idx_next;
      r_vector  <= w_vector_next;
      r_level   <= w_level_next;
    end
  end

  assign vector    = r_vector;
  assign int_level = r_level;

endmodule

// File: tb/tb_intr_arb.sv
// tb_intr_arb: directed self-checking bench for the bus-request arbiter.
module tb_intr_arb;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_in;
  logic [63:0] vec_in;
  logic [2:0]  cpu_ipl;
  logic        interrupt_ack;
  logic        interrupt;
  logic [7:0]  vector;
  logic [2:0]  int_level;
  logic [7:0]  ack_out;

  int n_checks;
  int n_pass;

  intr_arb #(
    .NUM_SRC  (8),
    .SRC_LEVEL(24'o44445446)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .vec_in       (vec_in),
    .cpu_ipl      (cpu_ipl),
    .interrupt_ack(interrupt_ack),
    .interrupt    (interrupt),
    .vector       (vector),
    .int_level    (int_level),
    .ack_out      (ack_out)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the four visible outputs in one go.
  task automatic check_out(input string tag, input logic i_exp, input logic [7:0] v_exp,
                           input logic [2:0] l_exp, input logic [7:0] a_exp);
    check({tag, ".interrupt"}, 32'(interrupt), 32'(i_exp));
    check({tag, ".vector"},    32'(vector),    32'(v_exp));
    check({tag, ".int_level"}, 32'(int_level), 32'(l_exp));
    check({tag, ".ack_out"},   32'(ack_out),   32'(a_exp));
    $display("%0t %s irq=%b ipl=%0d ack_in=%b -> int=%b vec=%o lvl=%0d ack=%b",
             $time, tag, irq_in, cpu_ipl, interrupt_ack, interrupt, vector, int_level, ack_out);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    irq_in        = 8'd0;
    vec_in        = 64'd0;
    cpu_ipl       = 3'd0;
    interrupt_ack = 1'b0;
    vec_in[8*0 +: 8] = 8'o100;
    vec_in[8*1 +: 8] = 8'o60;
    vec_in[8*2 +: 8] = 8'o70;
    vec_in[8*3 +: 8] = 8'o220;

    tick();
    tick();
    check_out("reset", 1'b0, 8'd0, 3'd0, 8'h00);
    reset = 1'b0;
    tick();
    check_out("idle_quiet", 1'b0, 8'd0, 3'd0, 8'h00);

    // 1: single clock request, one-cycle latency, then acknowledge
    irq_in = 8'b0000_0001;
    tick();
    check_out("t1_req", 1'b1, 8'o100, 3'd6, 8'h00);
    interrupt_ack = 1'b1;
    tick();
    check_out("t1_ack", 1'b0, 8'o100, 3'd6, 8'h01);
    interrupt_ack = 1'b0;
    irq_in        = 8'd0;
    tick();
    check_out("t1_wait", 1'b0, 8'o100, 3'd6, 8'h00);
    tick();
    check_out("t1_idle", 1'b0, 8'o100, 3'd6, 8'h00);

    // 2: s1 and s3 together -> s3 (level 5); then s1 after s3 drops
    irq_in = 8'b0000_1010;
    tick();
    check_out("t2_req_s3", 1'b1, 8'o220, 3'd5, 8'h00);
    interrupt_ack = 1'b1;
    tick();
    check_out("t2_ack_s3", 1'b0, 8'o220, 3'd5, 8'h08);
    interrupt_ack = 1'b0;
    irq_in        = 8'b0000_0010;
    tick();
    check_out("t2_wait", 1'b0, 8'o220, 3'd5, 8'h00);
    tick();
    check_out("t2_idle_gap", 1'b0, 8'o220, 3'd5, 8'h00);
    tick();
    check_out("t2_req_s1", 1'b1, 8'o60, 3'd4, 8'h00);
    interrupt_ack = 1'b1;
    tick();
    check_out("t2_ack_s1", 1'b0, 8'o60, 3'd4, 8'h02);
    interrupt_ack = 1'b0;
    irq_in        = 8'd0;
    tick();
    tick();

    // 3: IPL masking is strict; lowering IPL releases the request
    irq_in  = 8'b0000_0010;
    cpu_ipl = 3'd4;
    tick();
    check_out("t3_masked_a", 1'b0, 8'o60, 3'd4, 8'h00);
    tick();
    check("t3_masked_b.interrupt", 32'(interrupt), 32'd0);
    cpu_ipl = 3'd3;
    tick();
    check_out("t3_unmasked", 1'b1, 8'o60, 3'd4, 8'h00);
    cpu_ipl = 3'd4;
    tick();
    check_out("t3_ipl_raised", 1'b0, 8'o60, 3'd4, 8'h00);
    cpu_ipl = 3'd0;
    irq_in  = 8'd0;
    tick();

    // 4: higher-level source arrives while s1 is requesting
    irq_in = 8'b0000_0010;
    tick();
    check_out("t4_req_s1", 1'b1, 8'o60, 3'd4, 8'h00);
    irq_in = 8'b0000_0011;
    tick();
    check_out("t4_switch_s0", 1'b1, 8'o100, 3'd6, 8'h00);
    interrupt_ack = 1'b1;
    tick();
    check_out("t4_ack_s0", 1'b0, 8'o100, 3'd6, 8'h01);
    interrupt_ack = 1'b0;
    irq_in        = 8'd0;
    tick();
    tick();

    // 5: request withdrawn before ack; stray ack in IDLE
    irq_in = 8'b0000_0100;
    tick();
    check_out("t5_req_s2", 1'b1, 8'o70, 3'd4, 8'h00);
    irq_in = 8'd0;
    tick();
    check_out("t5_dropped", 1'b0, 8'o70, 3'd4, 8'h00);
    interrupt_ack = 1'b1;
    tick();
    check_out("t5_stray_ack", 1'b0, 8'o70, 3'd4, 8'h00);
    interrupt_ack = 1'b0;
    tick();

    // Ack coinciding with a new winner: old winner is acknowledged
    irq_in = 8'b0000_0010;
    tick();
    check_out("tc_req_s1", 1'b1, 8'o60, 3'd4, 8'h00);
    irq_in        = 8'b0000_0011;
    interrupt_ack = 1'b1;
    tick();
    check_out("tc_ack_old", 1'b0, 8'o60, 3'd4, 8'h02);
    interrupt_ack = 1'b0;
    irq_in        = 8'b0000_0001;
    tick();
    check_out("tc_wait", 1'b0, 8'o60, 3'd4, 8'h00);
    tick();
    check_out("tc_idle_gap", 1'b0, 8'o60, 3'd4, 8'h00);
    tick();
    check_out("tc_req_s0", 1'b1, 8'o100, 3'd6, 8'h00);
    interrupt_ack = 1'b1;
    tick();
    check_out("tc_ack_s0", 1'b0, 8'o100, 3'd6, 8'h01);
    interrupt_ack = 1'b0;
    irq_in        = 8'd0;
    tick();
    tick();

    // 6: reset during ACK aborts everything
    irq_in = 8'b0000_0001;
    tick();
    check_out("t6_req", 1'b1, 8'o100, 3'd6, 8'h00);
    interrupt_ack = 1'b1;
    tick();
    check_out("t6_ack", 1'b0, 8'o100, 3'd6, 8'h01);
    interrupt_ack = 1'b0;
    reset         = 1'b1;
    tick();
    check_out("t6_reset", 1'b0, 8'd0, 3'd0, 8'h00);
    reset  = 1'b0;
    irq_in = 8'd0;
    tick();
    check_out("t6_after", 1'b0, 8'd0, 3'd0, 8'h00);
    tick();
    check_out("t6_idle", 1'b0, 8'd0, 3'd0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
